// File: rtl/axi4l_mst_pkg.sv
// Shared types and constants for the AXI4-Lite single-beat master core.
package axi4l_mst_pkg;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4
    } state_e;

    // AXI response codes
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Fixed sideband values driven on every request
    localparam logic [2:0] PROT_DEFAULT = 3'b000;
    localparam logic [3:0] STRB_ALL     = 4'hF;

    // Anything other than OKAY counts as a failed transaction
    function automatic logic resp_is_err(input logic [1:0] r);
        return (r != OKAY);
    endfunction

endpackage

// File: rtl/axi4l_mst_core.sv
// AXI4-Lite master core: turns a one-cycle command pulse into a single
// AXI4-Lite write (AW+W then B) or read (AR then R) transaction.
// All AXI valids/readies are registered, so none depends on its own ready.
// Optional feature: define AXI4L_MST_ERR_EN to get a sticky error flag that
// sets on a non-OKAY completion and clears on the next accepted command;
// without it err is tied low.
module axi4l_mst_core
    import axi4l_mst_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // command side
    input  logic              txn,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              done,
    output logic [1:0]        resp,
    output logic              err,
    // AW channel
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    // W channel
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    // B channel
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    // AR channel
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    // R channel
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    state_e            state_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic              aw_done_q, w_done_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q, done_q;
    logic [1:0]        resp_q;

    logic              accept;
    logic              aw_done_d, w_done_d;
    logic              cpl;
    logic [1:0]        cpl_resp;

    // Command acceptance, per-channel handshake progress and completion detect
    always_comb begin
        accept    = (state_q == IDLE) && txn;
        aw_done_d = aw_done_q || (awvalid_q && m_axi_awready);
        w_done_d  = w_done_q  || (wvalid_q  && m_axi_wready);
        cpl       = ((state_q == WRESP) && m_axi_bvalid) ||
                    ((state_q == RDATA) && m_axi_rvalid);
        cpl_resp  = rw_q ? m_axi_rresp : m_axi_bresp;
    end

    // Transaction sequencer with registered AXI handshake and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            done_q    <= 1'b0;
            resp_q    <= OKAY;
        end else begin
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            if (cpl) begin
                resp_q <= cpl_resp;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rw_q      <= rw;
                        addr_q    <= addr;
                        wdata_q   <= wdata;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        if (rw) begin
                            arvalid_q <= 1'b1;
                            state_q   <= RADDR;
                        end else begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WADDR;
                        end
                    end
                end
                WADDR: begin
                    // AW and W retire independently; leave once both have
                    if (awvalid_q && m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid_q && m_axi_wready) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WRESP;
                    end
                end
                WRESP: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                RADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RDATA;
                    end
                end
                RDATA: begin
                    if (m_axi_rvalid) begin
                        rready_q <= 1'b0;
                        rdata_q  <= m_axi_rdata;
                        rvalid_q <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AXI4L_MST_ERR_EN
    logic err_q;

    // Sticky error: cleared by a newly accepted command, set by a failed completion
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (cpl && resp_is_err(cpl_resp)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign rvalid        = rvalid_q;
    assign rdata         = rdata_q;
    assign resp          = resp_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = PROT_DEFAULT;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = STRB_ALL;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = PROT_DEFAULT;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi4l_mst_core.sv
// Bench for axi4l_mst_core: memory-mode AXI4-Lite slave with per-channel
// programmable wait states and response codes, a vector table, a few
// hand-written corner sequences and a randomized run against a memory model.
module tb_axi4l_mst_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        txn = 1'b0;
    logic        rw = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid, busy, done, err;
    logic [1:0]  resp;

    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = 2'b00;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    axi4l_mst_core #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .txn(txn), .rw(rw), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rvalid(rvalid), .busy(busy), .done(done), .resp(resp), .err(err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // ---------------- slave state ----------------
    int cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0, cfg_ar_d = 0, cfg_r_d = 0;
    logic [1:0] cfg_resp = 2'b00;
    logic srst = 1'b0;
    int cyc = 0, done_cnt = 0, rv_cnt = 0, proto_err = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int aw_fire_cyc = 0, w_fire_cyc = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit aw_fire = 0, w_fire = 0, b_fire = 0, ar_fire = 0, r_fire = 0;
    bit aw_ok = 0, w_ok = 0, wr_pend = 0, rd_pend = 0;
    bit aw_seen = 0, w_seen = 0, ar_seen = 0;
    logic [31:0] aw_first = '0, w_first = '0, ar_first = '0;
    logic [31:0] aw_addr_l = '0, w_data_l = '0, ar_addr_l = '0, rd_addr = '0;
    logic [31:0] mem [logic [31:0]];

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] last_rdata = '0;

    typedef struct {
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  sresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave acts on the falling edge: it first retires handshakes that took
    // place on the preceding rising edge, then sets up the next one.
    task automatic slave_step();
        cyc++;
        if (done) done_cnt++;
        if (rvalid) rv_cnt++;
        if (srst) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            m_axi_arready = 0; m_axi_rvalid = 0;
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
            aw_ok = 0; w_ok = 0; wr_pend = 0; rd_pend = 0;
            aw_seen = 0; w_seen = 0; ar_seen = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            return;
        end
        if (aw_fire) begin aw_hs++; aw_fire_cyc = cyc; aw_ok = 1; aw_seen = 0; aw_cnt = 0; end
        if (w_fire)  begin w_hs++;  w_fire_cyc = cyc;  w_ok = 1;  w_seen = 0;  w_cnt = 0;  end
        if (aw_ok && w_ok) begin
            mem[aw_addr_l] = w_data_l;
            aw_ok = 0; w_ok = 0; wr_pend = 1; b_cnt = 0;
        end
        if (b_fire) begin b_hs++; m_axi_bvalid = 0; wr_pend = 0; end
        if (ar_fire) begin
            ar_hs++; ar_seen = 0; ar_cnt = 0; rd_pend = 1; rd_addr = ar_addr_l; r_cnt = 0;
        end
        if (r_fire) begin r_hs++; m_axi_rvalid = 0; rd_pend = 0; end

        if (m_axi_awvalid) begin
            if (!aw_seen) begin aw_seen = 1; aw_first = m_axi_awaddr; end
            else if (m_axi_awaddr !== aw_first) proto_err++;
            if (aw_cnt >= cfg_aw_d) m_axi_awready = 1;
            else begin m_axi_awready = 0; aw_cnt++; end
        end else begin
            if (aw_seen) proto_err++;
            aw_seen = 0; m_axi_awready = 0;
        end
        if (m_axi_wvalid) begin
            if (!w_seen) begin w_seen = 1; w_first = m_axi_wdata; end
            else if (m_axi_wdata !== w_first) proto_err++;
            if (w_cnt >= cfg_w_d) m_axi_wready = 1;
            else begin m_axi_wready = 0; w_cnt++; end
        end else begin
            if (w_seen) proto_err++;
            w_seen = 0; m_axi_wready = 0;
        end
        if (m_axi_arvalid) begin
            if (!ar_seen) begin ar_seen = 1; ar_first = m_axi_araddr; end
            else if (m_axi_araddr !== ar_first) proto_err++;
            if (ar_cnt >= cfg_ar_d) m_axi_arready = 1;
            else begin m_axi_arready = 0; ar_cnt++; end
        end else begin
            if (ar_seen) proto_err++;
            ar_seen = 0; m_axi_arready = 0;
        end
        if (wr_pend && !m_axi_bvalid) begin
            if (b_cnt >= cfg_b_d) begin m_axi_bvalid = 1; m_axi_bresp = cfg_resp; end
            else b_cnt++;
        end
        if (rd_pend && !m_axi_rvalid) begin
            if (r_cnt >= cfg_r_d) begin
                m_axi_rvalid = 1;
                m_axi_rdata  = mem.exists(rd_addr) ? mem[rd_addr] : 32'h0;
                m_axi_rresp  = cfg_resp;
            end else r_cnt++;
        end

        aw_fire = m_axi_awvalid && m_axi_awready;
        if (aw_fire) aw_addr_l = m_axi_awaddr;
        w_fire = m_axi_wvalid && m_axi_wready;
        if (w_fire) w_data_l = m_axi_wdata;
        b_fire = m_axi_bvalid && m_axi_bready;
        ar_fire = m_axi_arvalid && m_axi_arready;
        if (ar_fire) ar_addr_l = m_axi_araddr;
        r_fire = m_axi_rvalid && m_axi_rready;
    endtask

    initial forever begin
        @(negedge clk);
        slave_step();
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(bit r, logic [31:0] a, logic [31:0] d, int awd, int wd, int bd,
                                int ard, int rd, logic [1:0] sr, logic [31:0] er, int lat);
        vec_t v;
        v.rw = r; v.addr = a; v.wdata = d;
        v.aw_d = awd; v.w_d = wd; v.b_d = bd; v.ar_d = ard; v.r_d = rd;
        v.sresp = sr; v.exp_rdata = er; v.exp_resp = sr; v.exp_lat = lat;
        return v;
    endfunction

    task automatic set_cfg(input vec_t v);
        cfg_aw_d = v.aw_d; cfg_w_d = v.w_d; cfg_b_d = v.b_d;
        cfg_ar_d = v.ar_d; cfg_r_d = v.r_d; cfg_resp = v.sresp;
    endtask

    task automatic wait_done(inout int lat);
        while (!done && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    // Issue one command, follow it to completion and compare against v.
    task automatic run_txn(input vec_t v, input string tag);
        int lat;
        logic exp_err;
        set_cfg(v);
        txn = 1; rw = v.rw; addr = v.addr; wdata = v.wdata;
        tick();
        txn = 0; rw = $urandom; addr = $urandom; wdata = $urandom;
        chk({tag, ".busy"}, busy, 1);
        chk({tag, ".done_low"}, done, 0);
        chk({tag, ".err_clear"}, err, 0);
        chk({tag, ".valids"}, {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid},
            v.rw ? 3'b001 : 3'b110);
        lat = 1;
        wait_done(lat);
        chk({tag, ".latency"}, lat, v.exp_lat);
        chk({tag, ".resp"}, resp, v.exp_resp);
        chk({tag, ".rdata"}, rdata, v.rw ? v.exp_rdata : last_rdata);
        chk({tag, ".rvalid"}, rvalid, v.rw);
`ifdef AXI4L_MST_ERR_EN
        exp_err = (v.exp_resp != 2'b00);
`else
        exp_err = 1'b0;
`endif
        chk({tag, ".err"}, err, exp_err);
        chk({tag, ".busy_end"}, busy, 0);
        chk({tag, ".addr"}, v.rw ? ar_addr_l : aw_addr_l, v.addr);
        if (v.rw) last_rdata = v.exp_rdata;
        else ref_mem[v.addr] = v.wdata;
    endtask

    vec_t tbl[9];

    initial begin
        int d0, b0, a0, rv0, lat;
        vec_t v;

        tbl[0] = mk(0, 32'h44A0_0008, 32'h1234_5678, 0, 0, 0, 0, 0, 2'b00, 32'h0, 3);
        tbl[1] = mk(1, 32'h44A0_0008, 32'h0,         0, 0, 0, 2, 1, 2'b00, 32'h1234_5678, 6);
        tbl[2] = mk(1, 32'h44A0_0010, 32'h0,         0, 0, 0, 0, 0, 2'b10, 32'h0, 3);
        tbl[3] = mk(0, 32'h44A0_0010, 32'hCAFE_F00D, 1, 2, 1, 0, 0, 2'b00, 32'h0, 6);
        tbl[4] = mk(0, 32'h44A0_000C, 32'h0BAD_F00D, 0, 3, 0, 0, 0, 2'b11, 32'h0, 6);
        tbl[5] = mk(1, 32'h44A0_0010, 32'h0,         0, 0, 0, 0, 0, 2'b01, 32'hCAFE_F00D, 3);
        tbl[6] = mk(1, 32'h44A0_000C, 32'h0,         0, 0, 0, 1, 2, 2'b00, 32'h0BAD_F00D, 6);
        tbl[7] = mk(0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 2, 2, 0, 0, 0, 2'b00, 32'h0, 5);
        tbl[8] = mk(1, 32'hFFFF_FFFC, 32'h0,         0, 0, 0, 0, 0, 2'b00, 32'hFFFF_FFFF, 3);

        // Reset state
        tick(); tick();
        chk("rst.busy", busy, 0);
        chk("rst.done_rvalid", {done, rvalid}, 2'b00);
        chk("rst.rdata", rdata, 0);
        chk("rst.resp_err", {resp, err}, 3'b000);
        chk("rst.axi_ctl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'b0);
        chk("rst.addr_regs", {m_axi_awaddr, m_axi_wdata}, 64'h0);
        chk("const.prot_strb", {m_axi_awprot, m_axi_arprot, m_axi_wstrb}, {3'b000, 3'b000, 4'hF});
        rst = 0;
        tick();

        // Write then read back the same word
        d0 = done_cnt; rv0 = rv_cnt;
        run_txn(mk(0, 32'h44A0_0000, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 3), "wr_rd.w");
        run_txn(mk(1, 32'h44A0_0000, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 3), "wr_rd.r");
        tick();
        chk("wr_rd.done_count", done_cnt - d0, 2);
        chk("wr_rd.rvalid_count", rv_cnt - rv0, 1);

        // Vector table, issued back-to-back
        for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // AW held off three cycles while W goes at once
        tick();
        d0 = done_cnt; b0 = b_hs; a0 = aw_hs;
        v = mk(0, 32'h44A0_0020, 32'hA5A5_5A5A, 3, 0, 0, 0, 0, 2'b00, 32'h0, 6);
        set_cfg(v);
        txn = 1; rw = 0; addr = v.addr; wdata = v.wdata;
        tick();
        txn = 0; addr = 32'h0; wdata = 32'h0;
        chk("awdly.both_valid", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
        tick();
        chk("awdly.w_first", {m_axi_awvalid, m_axi_wvalid}, 2'b10);
        chk("awdly.awaddr", m_axi_awaddr, 32'h44A0_0020);
        lat = 2;
        wait_done(lat);
        chk("awdly.latency", lat, 6);
        tick(); tick();
        chk("awdly.order", w_fire_cyc < aw_fire_cyc, 1);
        chk("awdly.b_count", b_hs - b0, 1);
        chk("awdly.aw_count", aw_hs - a0, 1);
        chk("awdly.done_count", done_cnt - d0, 1);
        ref_mem[v.addr] = v.wdata;

        // Command pulsed while waiting in WRESP must be ignored
        d0 = done_cnt; a0 = aw_hs; b0 = b_hs;
        v = mk(0, 32'h44A0_0018, 32'h1111_2222, 0, 0, 3, 0, 0, 2'b00, 32'h0, 6);
        set_cfg(v);
        txn = 1; rw = 0; addr = v.addr; wdata = v.wdata;
        tick();
        txn = 0;
        lat = 1;
        while (!m_axi_bready && lat < 20) begin tick(); lat++; end
        chk("ign.in_wresp", m_axi_bready, 1);
        txn = 1; rw = 0; addr = 32'h44A0_0004; wdata = 32'h3333_4444;
        tick();
        txn = 0; lat++;
        wait_done(lat);
        chk("ign.latency", lat, 6);
        for (int k = 0; k < 4; k++) tick();
        chk("ign.busy", busy, 0);
        chk("ign.aw_count", aw_hs - a0, 1);
        chk("ign.b_count", b_hs - b0, 1);
        chk("ign.done_count", done_cnt - d0, 1);
        chk("ign.awaddr", aw_addr_l, 32'h44A0_0018);
        ref_mem[v.addr] = v.wdata;

        // Reset while waiting in RDATA, then a clean read
        v = mk(1, 32'h44A0_0008, 32'h0, 0, 0, 0, 0, 6, 2'b00, 32'h0, 3);
        set_cfg(v);
        txn = 1; rw = 1; addr = v.addr;
        tick();
        txn = 0;
        lat = 1;
        while (!m_axi_rready && lat < 20) begin tick(); lat++; end
        chk("rstmid.in_rdata", m_axi_rready, 1);
        rst = 1; srst = 1;
        tick();
        chk("rstmid.busy", busy, 0);
        chk("rstmid.axi_ctl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'b0);
        chk("rstmid.status", {done, rvalid, err, resp}, 5'b0);
        chk("rstmid.rdata", rdata, 0);
        rst = 0; srst = 0;
        last_rdata = 32'h0;
        tick();
        run_txn(mk(1, 32'h44A0_0008, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'h1234_5678, 3), "rstmid.read");

        // Randomized traffic against the memory model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            bit r;
            int awd, wd, bd, ard, rd, lt, mx;
            logic [1:0] sr;
            logic [31:0] er;
            r   = $urandom_range(0, 1);
            a   = 32'h44A0_0000 + 32'(4 * $urandom_range(0, 7));
            awd = $urandom_range(0, 3); wd = $urandom_range(0, 3); bd = $urandom_range(0, 3);
            ard = $urandom_range(0, 3); rd = $urandom_range(0, 3);
            sr  = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
            er  = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
            mx  = (awd > wd) ? awd : wd;
            lt  = r ? (3 + ard + rd) : (3 + mx + bd);
            run_txn(mk(r, a, $urandom, awd, wd, bd, ard, rd, sr, er, lt), $sformatf("rnd%0d", i));
        end

        tick(); tick();
        chk("protocol_violations", proto_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4l_mst_core.md
AXI4L_MST_CORE -- requirements
Module: axi4l_mst_core

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI data width (32 only supported).
REQ-003 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port txn  in  1  command start pulse, one cycle.
REQ-006 SHALL have port rw  in  1  0 = write, 1 = read; sampled with txn.
REQ-007 SHALL have port addr  in  ADDR_W  target byte address; sampled with txn.
REQ-008 SHALL have port wdata  in  DATA_W  write data; sampled with txn.
REQ-009 SHALL have port rdata  out  DATA_W  last read data.
REQ-010 SHALL have port rvalid  out  1  one-cycle pulse, rdata valid.
REQ-011 SHALL have port busy  out  1  transaction in flight.
REQ-012 SHALL have port done  out  1  one-cycle completion pulse, read or write.
REQ-013 SHALL have port resp  out  2  BRESP/RRESP of last transaction.
REQ-014 SHALL have port err  out  1  sticky error flag (see Configuration).
REQ-015 SHALL have ports m_axi_awaddr/awprot/awvalid  out  ADDR_W/3/1, and m_axi_awready in 1 (AW channel).
REQ-016 SHALL have ports m_axi_wdata/wstrb/wvalid  out  DATA_W/4/1, and m_axi_wready in 1 (W channel).
REQ-017 SHALL have ports m_axi_bresp in 2, m_axi_bvalid in 1, and m_axi_bready out 1 (B channel).
REQ-018 SHALL have ports m_axi_araddr/arprot/arvalid  out  ADDR_W/3/1, and m_axi_arready in 1 (AR channel).
REQ-019 SHALL have ports m_axi_rdata in DATA_W, m_axi_rresp in 2, m_axi_rvalid in 1, and m_axi_rready out 1 (R channel).

Function
REQ-020 SHALL implement the FSM states IDLE, WADDR, WRESP, RADDR, RDATA.
REQ-021 In IDLE, txn=1 SHALL capture addr/wdata/rw into registers and go to WADDR (rw=0) or RADDR (rw=1) on the next edge.
REQ-022 txn SHALL be ignored in every state except IDLE; captured command registers SHALL NOT change while busy.
REQ-023 busy SHALL be 1 exactly when the state is not IDLE.
REQ-024 In WADDR, awvalid and wvalid SHALL assert together; each SHALL drop independently on its own handshake; both done -> WRESP.
REQ-025 A valid, once asserted, SHALL be held with stable payload until its ready; a valid SHALL never depend combinationally on its ready.
REQ-026 In WRESP, bready=1; on bvalid, SHALL capture bresp into resp, pulse done, and return to IDLE.
REQ-027 In RADDR, arvalid=1 until arready, then -> RDATA.
REQ-028 In RDATA, rready=1; on rvalid, SHALL register rdata and rresp, pulse rvalid and done in the same cycle, and return to IDLE.
REQ-029 awprot/arprot SHALL be 3'b000 and wstrb SHALL be 4'hF constantly.
REQ-030 Minimum latency SHALL be: write txn->done 3 cycles, read txn->rvalid 3 cycles, with zero-wait slave.
REQ-031 rdata and resp SHALL hold their values until the next completing transaction.
REQ-032 Back-to-back: txn asserted in the cycle after done SHALL be accepted.

Reset
REQ-033 On rst, the state SHALL become IDLE on the next edge, including mid-transaction (the abort is the bench's responsibility).
REQ-034 Reset values SHALL be: all m_axi valids/readies 0, busy 0, done 0, rvalid 0, rdata 0, resp 2'b00, err 0, command registers 0.

Configuration
REQ-035 Macro AXI4L_MST_ERR_EN defined: err SHALL set on completion with resp != 2'b00 and clear on the next accepted txn. Not defined: err SHALL be tied 0 and no extra flop inferred.

Structure
REQ-036 Package axi4l_mst_pkg SHALL hold the FSM state enum and the response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
REQ-037 The design SHALL be a single module with no sub-module; the AW/W done flags SHALL be local flops.

Verification (AXI VIP slave, memory mode)
REQ-038 Bench SHALL cover: write addr=0x44A0_0000, wdata=0xDEADBEEF, then read the same address -> rdata=0xDEADBEEF, resp=OKAY, done twice.
REQ-039 Bench SHALL cover: awready delayed 3 cycles, wready immediate -> wvalid drops first, awaddr stable, single B handshake, done once.
REQ-040 Bench SHALL cover: slave returns rresp=SLVERR -> resp=2'b10; err=1 with AXI4L_MST_ERR_EN, err=0 without; next txn clears err.
REQ-041 Bench SHALL cover: txn pulsed during WRESP with addr=0x44A0_0004 -> ignored; no second AW issued.
REQ-042 Bench SHALL cover: rst asserted during RDATA -> next cycle busy=0, rready=0, all valids 0; a new read afterwards completes normally.
